obi_mem_bank_bridge: RTL and testbench
======================================

Name: obi_mem_bank_bridge

Overview:
- Sits directly downstream of one slave port of the system crossbar. Consumes one obi_req_t and returns one obi_resp_t.
- Drives a single SRAM bank interface with a fixed read latency. The bank may stall requests through mem_gnt_i, for example because of bank-side arbitration.
- Generates the OBI grant and the in-order rvalid/rdata response stream.
- Bounds the number of in-flight transactions.

Parameters:
- READ_LATENCY, 1, cycles from an accepted bank request to valid mem_rdata_i. Legal range 1..8.
- MAX_OUTSTANDING, 1, maximum accepted-but-unanswered transactions. Legal range 1..READ_LATENCY; an illegal value is an elaboration error.
- ADDR_WIDTH, 12, bank word-address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- slave_req_i  in  obi_req_t  request from the crossbar slave port (req, we, be, addr, wdata)
- slave_resp_o  out  obi_resp_t  response to the crossbar (gnt, rvalid, rdata)
- mem_req_o  out  1  bank request
- mem_gnt_i  in  1  bank accepts the request this cycle
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_WIDTH  word address, equal to slave_req_i.addr[ADDR_WIDTH+1:2]
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid READ_LATENCY cycles after acceptance

Behaviour:
- Reset: everything is synchronous to clk_i; rst_i is synchronous and active high.
  - While reset is asserted, the pipeline and counter are cleared, and slave_resp_o.rvalid=0 and rdata=0.
  - Reset asserted mid-operation drops all in-flight responses; no rvalid is produced for them afterwards.
  - gnt and mem_req_o are combinational and are forced to 0 during reset.
- full: asserted when outstanding count == MAX_OUTSTANDING.
- Request path, purely combinational:
  - mem_req_o = slave_req_i.req & ~full & ~rst_i.
  - slave_resp_o.gnt = mem_req_o & mem_gnt_i.
  - mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o pass through from slave_req_i.
  - addr[1:0] and the address bits above ADDR_WIDTH+1 are ignored.
- Acceptance: a transaction is accepted in a cycle with gnt=1.
  - The bridge never grants a request it did not forward to the bank.
  - Once full, mem_req_o is held low, so the bank never sees a request that cannot be answered.
- Latency pipeline: a READ_LATENCY-deep shift register of {valid, we} entries.
  - An accepted transaction enters stage 1 and retires at stage READ_LATENCY.
  - A retiring entry drives slave_resp_o.rvalid=1 for exactly one cycle.
  - Retiring read: rdata = mem_rdata_i.
  - Retiring write: rvalid is still asserted (OBI requires it), with rdata=32'h0.
  - Cycles with no retiring entry: rvalid=0 and rdata=32'h0.
- Ordering: responses are in acceptance order. With READ_LATENCY=1 and MAX_OUTSTANDING=1, back-to-back transactions get gnt every cycle, because retirement frees the slot before the next acceptance is evaluated.
- Counter: the outstanding count is width $clog2(MAX_OUTSTANDING+1).
  - Increments on accept, decrements on retire.
  - Accept and retire in the same cycle leave the count unchanged.
  - Retire counts as freeing a slot in the same cycle, so full is evaluated on (count - retire).
  - The counter never wraps; in simulation, an assertion fires on any overflow or underflow.
- Bank stall: with mem_gnt_i=0 the request stays pending, and slave_req_i must stay stable per OBI. No pipeline entry is created.

Optional Feature:
- Macro: OBI_MEM_BANK_BRIDGE_RESP_REG_EN.
- Defined:
  - rvalid and rdata are registered once more, so response latency is READ_LATENCY+1.
  - The output register counts toward the outstanding count, so MAX_OUTSTANDING may be up to READ_LATENCY+1.
  - The register resets to rvalid=0 and rdata=0.
- Undefined: responses are driven combinationally from the last pipeline stage (mem_rdata_i path) and latency is READ_LATENCY. This is the default.

Test Plan:
1. READ_LATENCY=1, MAX_OUTSTANDING=1, mem_gnt_i=1: read addr 32'h0000_0010 while the bank returns 32'hDEAD_BEEF → gnt in cycle 0, mem_addr_o=12'h004, rvalid=1 with rdata=32'hDEAD_BEEF in cycle 1.
2. Write addr 32'h20, be=4'b0011, wdata 32'h1234_5678 → mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=12'h008; in the next cycle rvalid=1 with rdata=32'h0.
3. READ_LATENCY=3, MAX_OUTSTANDING=2, req held high for 6 cycles → gnt pattern 1,1,0,1,1,0; rvalid in cycles 3,4,6,7 in order; mem_req_o=0 in cycle 2.
4. mem_gnt_i=0 for 3 cycles with req=1 → gnt=0 and no rvalid; after mem_gnt_i rises, one grant and exactly one rvalid READ_LATENCY cycles later.
5. READ_LATENCY=2: two reads accepted, rst_i asserted one cycle after the second → no rvalid after reset, count=0, and the next request is granted immediately.
6. With OBI_MEM_BANK_BRIDGE_RESP_REG_EN, READ_LATENCY=1: read returning 32'hCAFE_0001 → rvalid 2 cycles after gnt, rdata=32'hCAFE_0001.

Source files
------------

// File: rtl/obi_mem_bank_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_mem_bank_bridge                                                      |
// | OBI slave port to fixed-latency SRAM bank, in-order rvalid/rdata stream. |
// | Option macro: OBI_MEM_BANK_BRIDGE_RESP_REG_EN (extra response register). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

package obi_mem_bank_bridge_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_bank_bridge
  import obi_mem_bank_bridge_pkg::*;
#(
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 1,
  parameter int unsigned ADDR_WIDTH      = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  obi_req_t              slave_req_i,
  output obi_resp_t             slave_resp_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

`ifdef OBI_MEM_BANK_BRIDGE_RESP_REG_EN
  localparam int unsigned c_max_legal = READ_LATENCY + 1;
`else
  localparam int unsigned c_max_legal = READ_LATENCY;
`endif
  localparam int unsigned        c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 8 ||
        MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > c_max_legal) begin : g_bad_param
      $error("obi_mem_bank_bridge: illegal READ_LATENCY/MAX_OUTSTANDING");
    end
  endgenerate

  logic [READ_LATENCY-1:0] r_valid;
  logic [READ_LATENCY-1:0] r_we;
  logic [c_cnt_w-1:0]      r_count;
  logic [c_cnt_w-1:0]      w_count_free;
  logic                    w_full;
  logic                    w_accept;
  logic                    w_pipe_out;
  logic                    w_retire;
  logic                    w_rvalid;
  logic [31:0]             w_pipe_rdata;
  logic [31:0]             w_rdata;
  logic                    w_unused_addr;

  assign w_unused_addr = ^{slave_req_i.addr[31:ADDR_WIDTH+2], slave_req_i.addr[1:0]};

  // A slot retiring this cycle is already free for the request evaluated now.
  assign w_count_free = r_count - (w_retire ? c_one : '0);
  assign w_full       = (w_count_free == c_max_cnt);
  assign mem_req_o    = slave_req_i.req & ~w_full & ~rst_i;
  assign w_accept     = mem_req_o & mem_gnt_i;

  assign mem_we_o    = slave_req_i.we;
  assign mem_be_o    = slave_req_i.be;
  assign mem_addr_o  = slave_req_i.addr[ADDR_WIDTH+1:2];
  assign mem_wdata_o = slave_req_i.wdata;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_valid <= '0;
          r_we    <= '0;
        end else begin
          r_valid <= w_accept;
          r_we    <= w_accept & slave_req_i.we;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_valid <= '0;
          r_we    <= '0;
        end else begin
          r_valid <= {r_valid[READ_LATENCY-2:0], w_accept};
          r_we    <= {r_we[READ_LATENCY-2:0], w_accept & slave_req_i.we};
        end
      end
    end
  endgenerate

  assign w_pipe_out   = r_valid[READ_LATENCY-1];
  assign w_pipe_rdata = (w_pipe_out && !r_we[READ_LATENCY-1]) ? mem_rdata_i : 32'h0;

`ifdef OBI_MEM_BANK_BRIDGE_RESP_REG_EN
  logic        r_rvalid;
  logic [31:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_rvalid <= w_pipe_out;
      r_rdata  <= w_pipe_rdata;
    end
  end

  // The output register holds a transaction until it is presented, so it owns the slot.
  assign w_retire = r_rvalid;
  assign w_rvalid = r_rvalid;
  assign w_rdata  = r_rdata;
`else
  assign w_retire = w_pipe_out;
  assign w_rvalid = w_pipe_out;
  assign w_rdata  = w_pipe_rdata;
`endif

  always_comb begin
    slave_resp_o.gnt    = w_accept;
    slave_resp_o.rvalid = w_rvalid & ~rst_i;
    slave_resp_o.rdata  = rst_i ? 32'h0 : w_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_free + (w_accept ? c_one : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_accept && !w_retire && r_count == c_max_cnt));
      assert (!(w_retire && !w_accept && r_count == '0));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_bank_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obi_mem_bank_bridge                                                   |
// | Scoreboard bench: three bridge configurations driven by directed and     |
// | random OBI traffic. Honours OBI_MEM_BANK_BRIDGE_RESP_REG_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module tb_obi_mem_bank_bridge;
  import obi_mem_bank_bridge_pkg::*;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int LATS [N] = '{1, 3, 2};
  localparam int MAXS [N] = '{1, 2, 1};
`ifdef OBI_MEM_BANK_BRIDGE_RESP_REG_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obi_req_t          sreq   [N];
  obi_resp_t         sresp  [N];
  logic              rst_s  [N];
  logic              mgnt   [N];
  logic              mreq   [N];
  logic              mwe    [N];
  logic [3:0]        mbe    [N];
  logic [AW-1:0]     maddr  [N];
  logic [31:0]       mwdata [N];
  logic [31:0]       mrdata [N];

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] bank_fn(input int k, input int c);
    return 32'hDEAD_BEEF ^ {8'(k), 8'h00, 16'(c)};
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) mrdata[k] = bank_fn(k, cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  obi_mem_bank_bridge #(.READ_LATENCY(1), .MAX_OUTSTANDING(1), .ADDR_WIDTH(AW)) u_dut0 (
    .clk_i(clk), .rst_i(rst_s[0]), .slave_req_i(sreq[0]), .slave_resp_o(sresp[0]),
    .mem_req_o(mreq[0]), .mem_gnt_i(mgnt[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]),
    .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]));

  obi_mem_bank_bridge #(.READ_LATENCY(3), .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW)) u_dut1 (
    .clk_i(clk), .rst_i(rst_s[1]), .slave_req_i(sreq[1]), .slave_resp_o(sresp[1]),
    .mem_req_o(mreq[1]), .mem_gnt_i(mgnt[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]),
    .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]));

  obi_mem_bank_bridge #(.READ_LATENCY(2), .MAX_OUTSTANDING(1), .ADDR_WIDTH(AW)) u_dut2 (
    .clk_i(clk), .rst_i(rst_s[2]), .slave_req_i(sreq[2]), .slave_resp_o(sresp[2]),
    .mem_req_o(mreq[2]), .mem_gnt_i(mgnt[2]), .mem_we_o(mwe[2]), .mem_be_o(mbe[2]),
    .mem_addr_o(maddr[2]), .mem_wdata_o(mwdata[2]), .mem_rdata_i(mrdata[2]));

  // Reference model: outstanding count is the number of queued responses per instance.
  always @(negedge clk) begin
    int   idx;
    int   cnt;
    logic ret;
    logic full;
    logic ereq;
    logic egnt;
    for (int k = 0; k < N; k++) begin
      idx = -1;
      cnt = 0;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].k == k) begin
          cnt++;
          if (idx < 0) idx = i;
        end
      end
      if (rst_s[k]) begin
        chk("rst_rvalid", 32'(sresp[k].rvalid), 32'h0);
        chk("rst_rdata", sresp[k].rdata, 32'h0);
        chk("rst_gnt", 32'(sresp[k].gnt), 32'h0);
        chk("rst_mem_req", 32'(mreq[k]), 32'h0);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].k == k) sb.delete(i);
        end
      end else begin
        ret  = (idx >= 0) && (sb[idx].due == cyc);
        full = ((cnt - int'(ret)) == MAXS[k]);
        ereq = sreq[k].req && !full;
        egnt = ereq && mgnt[k];
        chk("mem_req", 32'(mreq[k]), 32'(ereq));
        chk("gnt", 32'(sresp[k].gnt), 32'(egnt));
        if (sreq[k].req) begin
          chk("mem_addr", 32'(maddr[k]), 32'(sreq[k].addr[AW+1:2]));
          chk("mem_we", 32'(mwe[k]), 32'(sreq[k].we));
          chk("mem_be", 32'(mbe[k]), 32'(sreq[k].be));
          chk("mem_wdata", mwdata[k], sreq[k].wdata);
        end
        chk("rvalid", 32'(sresp[k].rvalid), 32'(ret));
        if (ret) begin
          chk("rdata", sresp[k].rdata, sb[idx].data);
          sb.delete(idx);
        end else begin
          chk("rdata_idle", sresp[k].rdata, 32'h0);
        end
        if (egnt) begin
          sb.push_back('{k, cyc + LATS[k] + RR,
                         sreq[k].we ? 32'h0 : bank_fn(k, cyc + LATS[k])});
        end
      end
    end
  end

  function automatic int pending(input int k);
    int n = 0;
    foreach (sb[i]) if (sb[i].k == k) n++;
    return n;
  endfunction

  // Caller sits at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int stall);
    bit done = 1'b0;
    sreq[k] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wd};
    for (int i = 0; i < 40 && !done; i++) begin
      mgnt[k] = (i >= stall);
      @(negedge clk);
      if (sresp[k].gnt) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("grant_timeout", 32'h0, 32'h1);
    sreq[k].req = 1'b0;
    mgnt[k]     = 1'b1;
  endtask

  task automatic wait_idle(input int k);
    int i = 0;
    while (pending(k) != 0 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (pending(k) != 0) chk("drain_timeout", 32'(pending(k)), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    int         s;
    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b1;
      mgnt[k]  = 1'b1;
      sreq[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
    @(posedge clk); #1;

    // Single read and single write, then back-to-back reads.
    do_req(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 0);
    wait_idle(0);
    do_req(0, 1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 0);
    wait_idle(0);
    s = cyc;
    for (int i = 0; i < 4; i++) do_req(0, 1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0, 0);
    chk("b2b_cycles", 32'(cyc - s), RR != 0 ? 32'd7 : 32'd4);
    wait_idle(0);

    // Request held high for six cycles against the outstanding limit.
    sreq[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = sresp[1].gnt;
      @(posedge clk); #1;
    end
    sreq[1].req = 1'b0;
    chk("gnt_pattern", 32'(pat), RR != 0 ? 32'h33 : 32'h1B);
    wait_idle(1);

    // Bank stall for three cycles.
    do_req(1, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 3);
    wait_idle(1);

    // Reset while two reads are in flight drops their responses.
    do_req(2, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 0);
    do_req(2, 1'b0, 32'h0000_0204, 4'hF, 32'h0, 0);
    rst_s[2] = 1'b1;
    @(posedge clk); #1;
    rst_s[2] = 1'b0;
    sreq[2] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h208, wdata: 32'h0};
    @(negedge clk);
    chk("post_rst_gnt", 32'(sresp[2].gnt), 32'h1);
    @(posedge clk); #1;
    sreq[2].req = 1'b0;
    wait_idle(2);

    // Random traffic with random bank stalls across all instances.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, N - 1);
      do_req(k, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             $urandom, $urandom_range(0, 2));
    end
    for (int k = 0; k < N; k++) wait_idle(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
